ir_load_ctrl: RTL and testbench

Sequencer that owns the write side of the instruction register file. On a start request it fetches a block of instruction words from data memory through a request/acknowledge handshake and writes them into consecutive register-file entries (INIT → READ_MEM → WORK). It then hands the register file's read port to the core's fetch path until the next reload. It sits between the memory interface, the instruction register file and the fetch stage.

---
 rtl/ir_load_ctrl_if.sv | 46 ++++
 rtl/ir_load_ctrl.sv | 156 +++++++++++++++
 tb/tb_ir_load_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ir_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// ir_load_ctrl_if
// Bundles the instruction-register-file loader's bus signals: the start
// request, the memory read handshake, the register-file write/read port and
// the fetch-side status.
//   master : the loader (ir_load_ctrl) - drives o_*, samples i_*
//   slave  : the environment (memory, register file, fetch stage)
// Signals:
//   i_start, i_base, i_len       load request with base address and length
//   o_mem_req, o_mem_addr        memory read request / address
//   i_mem_ack, i_mem_data        one-cycle acknowledge with read data
//   o_rf_we, o_rf_addr, o_rf_data  register-file write enable / index / data
//   i_fetch_addr, o_fetch_ready  fetch-stage read index / contents valid
//   o_busy, o_done               load in progress / load-complete pulse
// ---------------------------------------------------------------------------
interface ir_load_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_base;
  logic [ADDR_WIDTH:0]   i_len;
  logic                  o_mem_req;
  logic [DATA_WIDTH-1:0] o_mem_addr;
  logic                  i_mem_ack;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic                  o_rf_we;
  logic [ADDR_WIDTH-1:0] o_rf_addr;
  logic [DATA_WIDTH-1:0] o_rf_data;
  logic [ADDR_WIDTH-1:0] i_fetch_addr;
  logic                  o_fetch_ready;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    input  i_start, i_base, i_len, i_mem_ack, i_mem_data, i_fetch_addr,
    output o_mem_req, o_mem_addr, o_rf_we, o_rf_addr, o_rf_data,
           o_fetch_ready, o_busy, o_done
  );

  modport slave (
    output i_start, i_base, i_len, i_mem_ack, i_mem_data, i_fetch_addr,
    input  o_mem_req, o_mem_addr, o_rf_we, o_rf_addr, o_rf_data,
           o_fetch_ready, o_busy, o_done
  );
endinterface

// File: rtl/ir_load_ctrl.sv
// ---------------------------------------------------------------------------
// ir_load_ctrl
// Owns the write side of the instruction register file. On an accepted start
// it reads i_len words from memory starting at i_base (request/acknowledge
// handshake) and writes them to register-file entries 0..i_len-1, then hands
// the register-file index over to the fetch stage (o_rf_addr = i_fetch_addr)
// until the next reload.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   io_bus   ir_load_ctrl_if.master (see interface file for the signal list)
// All outputs are registered except o_rf_addr while in WORK, where it is a
// combinational pass-through of i_fetch_addr.
// ---------------------------------------------------------------------------
module ir_load_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ir_load_ctrl_if.master io_bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_WORK  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH+1)'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_base;
  logic [DATA_WIDTH-1:0] w_base_nxt;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   w_len_nxt;
  // idx carries one extra bit so a full 2**ADDR_WIDTH load can terminate.
  logic [ADDR_WIDTH:0]   r_idx;
  logic [ADDR_WIDTH:0]   w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_rf_data;
  logic [DATA_WIDTH-1:0] w_rf_data_nxt;
  logic [ADDR_WIDTH-1:0] r_rf_addr;
  logic [ADDR_WIDTH-1:0] w_rf_addr_nxt;
  logic                  r_mem_req;
  logic                  r_rf_we;
  logic                  r_fetch_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_done_nxt;

  // Next-state and next-register computation for the load sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_base_nxt     = r_base;
    w_len_nxt      = r_len;
    w_idx_nxt      = r_idx;
    w_rf_data_nxt  = r_rf_data;
    w_rf_addr_nxt  = r_rf_addr;
    w_done_nxt     = 1'b0;
    w_mem_addr_nxt = r_mem_addr;

    case (r_state)
      ST_INIT, ST_WORK: begin
        if (io_bus.i_start) begin
          w_base_nxt = io_bus.i_base;
          w_len_nxt  = io_bus.i_len;
          w_idx_nxt  = '0;
          if (io_bus.i_len == '0) begin
            // Empty load: complete immediately without touching memory.
            w_state_nxt = ST_WORK;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_REQ: begin
        if (io_bus.i_mem_ack) begin
          // Data is captured straight into the write-data output register.
          w_rf_data_nxt = io_bus.i_mem_data;
          w_rf_addr_nxt = r_idx[ADDR_WIDTH-1:0];
          w_state_nxt   = ST_WRITE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WRITE: begin
        w_idx_nxt = r_idx + IDX_ONE;
        if ((r_idx + IDX_ONE) == r_len) begin
          w_state_nxt = ST_WORK;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase

    // The address is loaded on entry to REQ and then held for the whole wait.
    if (w_state_nxt == ST_REQ) begin
      w_mem_addr_nxt = w_base_nxt + DATA_WIDTH'(w_idx_nxt);
    end else begin
      w_mem_addr_nxt = r_mem_addr;
    end
  end

  // State, latches and registered outputs; outputs are decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_base        <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_mem_addr    <= '0;
      r_rf_data     <= '0;
      r_rf_addr     <= '0;
      r_mem_req     <= 1'b0;
      r_rf_we       <= 1'b0;
      r_fetch_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_base        <= w_base_nxt;
      r_len         <= w_len_nxt;
      r_idx         <= w_idx_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_rf_data     <= w_rf_data_nxt;
      r_rf_addr     <= w_rf_addr_nxt;
      r_mem_req     <= (w_state_nxt == ST_REQ);
      r_rf_we       <= (w_state_nxt == ST_WRITE);
      r_fetch_ready <= (w_state_nxt == ST_WORK);
      r_busy        <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_WRITE);
      r_done        <= w_done_nxt;
    end
  end

  assign io_bus.o_mem_req     = r_mem_req;
  assign io_bus.o_mem_addr    = r_mem_addr;
  assign io_bus.o_rf_we       = r_rf_we;
  assign io_bus.o_rf_data     = r_rf_data;
  // In WORK the register-file read index belongs to the fetch stage.
  assign io_bus.o_rf_addr     = (r_state == ST_WORK) ? io_bus.i_fetch_addr : r_rf_addr;
  assign io_bus.o_fetch_ready = r_fetch_ready;
  assign io_bus.o_busy        = r_busy;
  assign io_bus.o_done        = r_done;

endmodule

// File: tb/tb_ir_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ir_load_ctrl
// Directed bench for ir_load_ctrl. Expected register-file writes are pushed
// to a scoreboard queue when a load is started and popped as the DUT writes.
// ---------------------------------------------------------------------------
module tb_ir_load_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   cyc;
  logic [11:0] sb[$];

  ir_load_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  ir_load_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},   32'(bus.o_mem_req), 32'd0);
    check({tag, "_maddr"}, 32'(bus.o_mem_addr), 32'd0);
    check({tag, "_we"},    32'(bus.o_rf_we), 32'd0);
    check({tag, "_raddr"}, 32'(bus.o_rf_addr), 32'd0);
    check({tag, "_rdata"}, 32'(bus.o_rf_data), 32'd0);
    check({tag, "_ready"}, 32'(bus.o_fetch_ready), 32'd0);
    check({tag, "_busy"},  32'(bus.o_busy), 32'd0);
    check({tag, "_done"},  32'(bus.o_done), 32'd0);
  endtask

  // Full load: start, serve each request after wt wait cycles, check writes.
  task automatic do_load(input logic [7:0] base, input logic [4:0] len, input int wt,
                         input logic [7:0] dbase, input bit disturb);
    int t0;
    int n;
    logic [7:0]  a;
    logic [11:0] e;
    for (int k = 0; k < int'(len); k++) sb.push_back({4'(k), dbase + 8'(k)});
    bus.i_start = 1'b1;
    bus.i_base  = base;
    bus.i_len   = len;
    t0 = cyc;
    step();
    bus.i_start = 1'b0;
    bus.i_base  = 8'h00;
    bus.i_len   = 5'd0;
    if (len != 5'd0) check("ready_drop", 32'(bus.o_fetch_ready), 32'd0);
    for (int k = 0; k < int'(len); k++) begin
      n = 0;
      while (bus.o_mem_req !== 1'b1 && n < 50) begin
        step();
        n++;
      end
      check("req_rise", 32'(bus.o_mem_req), 32'd1);
      a = base + 8'(k);
      check("mem_addr", 32'(bus.o_mem_addr), 32'(a));
      check("busy_req", 32'(bus.o_busy), 32'd1);
      for (int w = 0; w < wt; w++) begin
        step();
        check("req_hold", 32'(bus.o_mem_req), 32'd1);
        check("addr_hold", 32'(bus.o_mem_addr), 32'(a));
      end
      bus.i_mem_ack  = 1'b1;
      bus.i_mem_data = dbase + 8'(k);
      if (disturb && k == 0) begin
        bus.i_start = 1'b1;
        bus.i_base  = 8'h99;
        bus.i_len   = 5'd0;
      end
      step();
      bus.i_mem_ack  = 1'b0;
      bus.i_mem_data = 8'h00;
      bus.i_start    = 1'b0;
      check("rf_we", 32'(bus.o_rf_we), 32'd1);
      check("req_fall", 32'(bus.o_mem_req), 32'd0);
      check("busy_wr", 32'(bus.o_busy), 32'd1);
      check("done_low", 32'(bus.o_done), 32'd0);
      check("ready_low", 32'(bus.o_fetch_ready), 32'd0);
      if (sb.size() > 0) e = sb.pop_front();
      else e = 'x;
      check("rf_addr", 32'(bus.o_rf_addr), 32'(e[11:8]));
      check("rf_data", 32'(bus.o_rf_data), 32'(e[7:0]));
      if (disturb && k == 0) begin
        // Spurious acknowledge while in WRITE.
        bus.i_mem_ack  = 1'b1;
        bus.i_mem_data = 8'hEE;
      end
      step();
      bus.i_mem_ack  = 1'b0;
      bus.i_mem_data = 8'h00;
    end
    check("done_cycle", 32'(cyc - t0), 32'(1 + int'(len) * (wt + 2)));
    check("done_pulse", 32'(bus.o_done), 32'd1);
    check("ready_up", 32'(bus.o_fetch_ready), 32'd1);
    check("busy_off", 32'(bus.o_busy), 32'd0);
    check("req_off", 32'(bus.o_mem_req), 32'd0);
    check("we_off", 32'(bus.o_rf_we), 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);
    step();
    check("done_once", 32'(bus.o_done), 32'd0);
    check("ready_hold", 32'(bus.o_fetch_ready), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_base       = 8'h00;
    bus.i_len        = 5'd0;
    bus.i_mem_ack    = 1'b0;
    bus.i_mem_data   = 8'h00;
    bus.i_fetch_addr = 4'h5;

    // Reset state, and idle afterwards with no start.
    step();
    check_idle("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("idle");
    end

    // Zero-wait load of four words.
    do_load(8'h20, 5'd4, 0, 8'hA0, 1'b0);
    bus.i_fetch_addr = 4'd2;
    #1;
    check("fetch_pass2", 32'(bus.o_rf_addr), 32'd2);
    bus.i_fetch_addr = 4'd13;
    #1;
    check("fetch_pass13", 32'(bus.o_rf_addr), 32'd13);
    step();

    // Address wrap with three-cycle ack delay.
    do_load(8'hFE, 5'd3, 3, 8'h10, 1'b0);

    // Empty load: done next cycle, no memory traffic.
    do_load(8'h33, 5'd0, 0, 8'h00, 1'b0);
    check("len0_req", 32'(bus.o_mem_req), 32'd0);

    // Restart in REQ and ack in WRITE are ignored.
    do_load(8'h80, 5'd3, 0, 8'h50, 1'b1);

    // Full-depth reload from WORK.
    do_load(8'h00, 5'd16, 0, 8'hC0, 1'b0);

    // Asynchronous reset while waiting for an acknowledge.
    bus.i_start = 1'b1;
    bus.i_base  = 8'h40;
    bus.i_len   = 5'd2;
    step();
    bus.i_start = 1'b0;
    check("pre_rst_req", 32'(bus.o_mem_req), 32'd1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    step();
    rst_n = 1'b1;
    step();
    check_idle("postrst");
    do_load(8'h40, 5'd2, 1, 8'h70, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
